// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: signed (x,y) -> magnitude (gain kept) and phase.
// One micro-rotation per clock, one request in flight.
`timescale 1ns/1ps
module cordic_vector #(
  parameter int XY_BITS    = 12,
  parameter int PH_BITS    = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic signed [XY_BITS-1:0] x_i,
  input  logic signed [XY_BITS-1:0] y_i,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [XY_BITS+1:0]        mag_o,
  output logic [PH_BITS-1:0]        phase_out,
  output logic                      valid_out
);

  localparam int W  = XY_BITS + 2;
  localparam int G  = 16;
  localparam int DW = W + G;
  localparam logic [PH_BITS-1:0] HALF =
    {1'b1, {(PH_BITS-1){1'b0}}};

  typedef enum logic {IDLE, ITER} state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q;
  logic signed [DW-1:0] x_q, y_q;
  logic signed [DW-1:0] x_d, y_d;
  logic signed [DW-1:0] x_sh, y_sh;
  logic signed [DW-1:0] x_in, y_in;
  logic [PH_BITS-1:0]   z_q, z_d, atan_ph;
  logic [31:0]          atan32;
  logic                 zero_q, accept, last;

  function automatic logic [31:0] atan_lut(
    input logic [4:0] i
  );
    case (i)
      5'd0:    atan_lut = 32'h20000000;
      5'd1:    atan_lut = 32'h12E4051E;
      5'd2:    atan_lut = 32'h09FB385B;
      5'd3:    atan_lut = 32'h051111D4;
      5'd4:    atan_lut = 32'h028B0D43;
      5'd5:    atan_lut = 32'h0145D7E1;
      5'd6:    atan_lut = 32'h00A2F61E;
      5'd7:    atan_lut = 32'h00517C55;
      5'd8:    atan_lut = 32'h0028BE53;
      5'd9:    atan_lut = 32'h00145F2F;
      5'd10:   atan_lut = 32'h000A2F98;
      5'd11:   atan_lut = 32'h000517CC;
      5'd12:   atan_lut = 32'h00028BE6;
      5'd13:   atan_lut = 32'h000145F3;
      5'd14:   atan_lut = 32'h0000A2FA;
      5'd15:   atan_lut = 32'h0000517D;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  assign ready_out = (state_q == IDLE);
  assign accept    = ready_out && valid_in;
  assign last      = (state_q == ITER) &&
                     (cnt_q == 5'(ITERATIONS-1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ITER;
      ITER:    if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fractional guard bits keep the residual angle well under one LSB of y.
  assign x_in = {{(W-XY_BITS){x_i[XY_BITS-1]}}, x_i, {G{1'b0}}};
  assign y_in = {{(W-XY_BITS){y_i[XY_BITS-1]}}, y_i, {G{1'b0}}};

  always_comb begin
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;
    atan32  = atan_lut(cnt_q);
    atan_ph = atan32[31 -: PH_BITS];
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    if (!y_q[DW-1]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_ph;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_ph;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      mag_o     <= '0;
      phase_out <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        cnt_q  <= '0;
        zero_q <= (x_i == '0) && (y_i == '0);
        if (x_i[XY_BITS-1]) begin
          x_q <= -x_in;
          y_q <= -y_in;
          z_q <= HALF;
        end else begin
          x_q <= x_in;
          y_q <= y_in;
          z_q <= '0;
        end
      end else if (state_q == ITER) begin
        x_q   <= x_d;
        y_q   <= y_d;
        z_q   <= z_d;
        cnt_q <= cnt_q + 5'd1;
        if (last) begin
          mag_o     <= x_d[DW-1:G];
          phase_out <= zero_q ? '0 : z_d;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: directed vectors,
// expected magnitude/phase pushed at accept, checked at valid_out.
`timescale 1ns/1ps
module tb_cordic_vector;

  logic               clk_in = 1'b0;
  logic               rst_n  = 1'b0;
  logic signed [11:0] x_i    = '0;
  logic signed [11:0] y_i    = '0;
  logic               valid_in = 1'b0;
  logic               ready_out;
  logic [13:0]        mag_o;
  logic [31:0]        phase_out;
  logic               valid_out;

  cordic_vector dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .x_i       (x_i),
    .y_i       (y_i),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mag_o     (mag_o),
    .phase_out (phase_out),
    .valid_out (valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          mag;
    logic [31:0] ph;
    int          acc;
  } exp_t;

  typedef struct {
    logic signed [11:0] x;
    logic signed [11:0] y;
    int                 mag;
    logic [31:0]        ph;
  } vec_t;

  localparam int N = 13;

  exp_t        sb[$];
  vec_t        tbl[N];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_push  = 0;
  int          cyc     = 0;
  int          exp_mag_drv = 0;
  logic [31:0] exp_ph_drv  = '0;
  logic [13:0] last_mag = '0;
  logic [31:0] last_ph  = '0;
  logic        prev_v   = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic watcher();
    forever begin
      @(negedge clk_in);
      if (rst_n && valid_in && ready_out) begin
        sb.push_back('{exp_mag_drv, exp_ph_drv, cyc + 1});
        n_push++;
      end
    end
  endtask

  task automatic monitor();
    exp_t        e;
    int          dm;
    int          dp;
    logic [31:0] dph;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else if (valid_out) begin
        if (prev_v) begin
          n_tests++; n_fail++;
          $display("FAIL valid_width: valid_out high 2 cycles");
        end
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid: mag %0d phase %h",
                   mag_o, phase_out);
        end else begin
          e   = sb.pop_front();
          dm  = int'(mag_o) - e.mag;
          dph = phase_out - e.ph;
          dp  = int'(signed'(dph));
          n_tests += 3;
          if (dm > 3 || dm < -3) begin
            n_fail++;
            $display("FAIL mag: got %0d expected %0d +/-3",
                     mag_o, e.mag);
          end
          if (dp > 32768 || dp < -32768) begin
            n_fail++;
            $display("FAIL phase: got %h expected %h +/-8000",
                     phase_out, e.ph);
          end
          if (cyc - e.acc != 16) begin
            n_fail++;
            $display("FAIL latency: got %0d expected 16",
                     cyc - e.acc);
          end
        end
      end else if (mag_o !== last_mag ||
                   phase_out !== last_ph) begin
        n_tests++; n_fail++;
        $display("FAIL hold: mag %0d/%0d phase %h/%h",
                 mag_o, last_mag, phase_out, last_ph);
      end
      last_mag = mag_o;
      last_ph  = phase_out;
      prev_v   = valid_out && rst_n;
    end
  endtask

  task automatic drive(input int k);
    x_i         = tbl[k].x;
    y_i         = tbl[k].y;
    exp_mag_drv = tbl[k].mag;
    exp_ph_drv  = tbl[k].ph;
  endtask

  task automatic send(input int k);
    int n = 0;
    while (!ready_out && n < 40) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (n >= 40) chk("ready_timeout", 0, 1);
    drive(k);
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(posedge clk_in); #1;
  endtask

  initial begin
    int p0;
    tbl[0]  = '{ 12'sd1000,     12'sd0,    1647, 32'h00000000};
    tbl[1]  = '{ 12'sd0,        12'sd1000, 1647, 32'h40000000};
    tbl[2]  = '{-12'sd1000,     12'sd0,    1647, 32'h80000000};
    tbl[3]  = '{ 12'sd0,       -12'sd1000, 1647, 32'hC0000000};
    tbl[4]  = '{-12'sd2048,    -12'sd2048, 4770, 32'hA0000000};
    tbl[5]  = '{ 12'sd2047,    -12'sd2048, 4768, 32'hDFFD73F1};
    tbl[6]  = '{ 12'sd0,        12'sd0,    0,    32'h00000000};
    tbl[7]  = '{ 12'sd600,      12'sd800,  1647, 32'h25C80A3B};
    tbl[8]  = '{-12'sd600,     -12'sd800,  1647, 32'hA5C80A3B};
    tbl[9]  = '{-12'sd2048,     12'sd0,    3373, 32'h80000000};
    tbl[10] = '{ 12'sd2047,     12'sd2047, 4767, 32'h20000000};
    tbl[11] = '{ 12'sd1000,    -12'sd1,    1647, 32'hFFF591D3};
    tbl[12] = '{-12'sd1000,     12'sd1,    1647, 32'h7FF591D3};

    #12;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_mag",   mag_o,     0);
    chk("rst_phase", phase_out, 0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;

    fork
      watcher();
      monitor();
    join_none

    for (int k = 0; k < N; k++) begin
      send(k);
      wait_idle("single");
    end

    p0 = n_push;
    valid_in = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive(c % N);
      @(posedge clk_in); #1;
    end
    valid_in = 1'b0;
    chk("stream_accepts", n_push - p0, 4);
    wait_idle("stream");

    send(0);
    repeat (7) @(posedge clk_in);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #2;
    chk("midrst_ready", ready_out, 1);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_mag",   mag_o,     0);
    chk("midrst_phase", phase_out, 0);
    @(posedge clk_in); #2;
    rst_n = 1'b1;
    repeat (25) @(posedge clk_in);
    #1;
    chk("postrst_ready", ready_out, 1);

    send(7);
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
